// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Single-outstanding instruction fetch front end. Issues one read request
//   per instruction, captures the response, and holds it for the decode stage
//   until it is accepted. A taken-branch redirect overrides every other
//   transition and re-steers the PC.
//
// Parameters
//   RESET_PC         PC loaded on reset
//
// Ports
//   clk              clock, all state updates on the rising edge
//   rst              synchronous active-high reset
//   imem_req         one-cycle read request (only while fetching)
//   imem_addr        fetch address, valid while imem_req=1
//   imem_valid       read response strobe
//   imem_rdata       read response word
//   inst             instruction presented to decode
//   inst_pc          address of inst
//   inst_valid       inst/inst_pc hold a valid instruction
//   inst_ready       decode accepts inst this cycle
//   redirect         taken-branch redirect
//   redirect_target  new PC, low two bits forced to zero
//
// Build option
//   FETCH_NOP_SQUASH_EN  when defined, NOP responses (32'hD503201F) are
//                        skipped instead of being presented to decode
//
// States
//   S_REQ  | drive imem_req with the current PC
//   S_WAIT | request outstanding, waiting for imem_valid
//   S_HOLD | instruction presented, waiting for inst_ready
//   S_DROP | request outstanding but redirected away; discard its response
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [63:0] redirect_target
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

`ifdef FETCH_NOP_SQUASH_EN
    localparam logic [31:0] NOP_WORD = 32'hD503201F;
`endif

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [63:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [63:0] pc_inc;

    // Wraps modulo 2^64 by construction.
    assign pc_inc = pc_q + 64'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;

        if (redirect) begin
            pc_d         = redirect_target & ~64'h3;
            inst_valid_d = 1'b0;
            case (state_q)
                S_REQ, S_HOLD: state_d = S_REQ;
                // A response landing in the redirect cycle is the outstanding
                // one; it is dropped here, so there is nothing left to wait
                // for. Otherwise park in S_DROP until it shows up. The same
                // holds for a repeated redirect while already dropping, or
                // S_DROP would wait forever for a response already consumed.
                S_WAIT, S_DROP: state_d = imem_valid ? S_REQ : S_DROP;
                default:        state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: state_d = S_WAIT;
                S_WAIT: begin
                    if (imem_valid) begin
`ifdef FETCH_NOP_SQUASH_EN
                        if (imem_rdata == NOP_WORD) begin
                            pc_d    = pc_inc;
                            state_d = S_REQ;
                        end else begin
                            inst_d       = imem_rdata;
                            inst_pc_d    = pc_q;
                            inst_valid_d = 1'b1;
                            state_d      = S_HOLD;
                        end
`else
                        inst_d       = imem_rdata;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = S_HOLD;
`endif
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        pc_d         = pc_inc;
                        inst_valid_d = 1'b0;
                        state_d      = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_valid) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0;
            inst_pc_q    <= 64'h0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Gated by rst so no request escapes while reset is held.
    assign imem_req   = (state_q == S_REQ) && !rst;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [63:0] RPC = 64'h1000;
    localparam logic [31:0] NOP = 32'hD503201F;
`ifdef FETCH_NOP_SQUASH_EN
    localparam bit SQUASH = 1'b1;
`else
    localparam bit SQUASH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_target = 64'h0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .redirect(redirect), .redirect_target(redirect_target)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Transaction-level model: what the fetcher owes the outside world.
    bit          m_known = 1'b0;   // a reset has been applied
    bit          m_req_pend = 1'b0; // a fetch of m_fpc is due this cycle
    bit          m_busy = 1'b0;     // a read is outstanding at the memory
    bit          m_discard = 1'b0;  // outstanding read was redirected away
    bit          m_valid = 1'b0;
    logic [31:0] m_inst = 32'h0;
    logic [63:0] m_pc = 64'h0;
    logic [63:0] m_fpc = 64'h0;

    // Memory: one pending response with a countdown.
    int          resp_cnt = 0;
    logic [63:0] resp_addr = 64'h0;

    logic [63:0] req_log[$];
    logic [63:0] vpc_log[$];
    logic [31:0] vinst_log[$];
    int          vcyc_log[$];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h1004) return 32'h8B020020;
        if (a[6:2] == 5'd0 && a[12]) return NOP;
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic clear_logs();
        req_log.delete();
        vpc_log.delete();
        vinst_log.delete();
        vcyc_log.delete();
    endtask

    task automatic tick(input bit r, input bit rd, input logic [63:0] tg,
                        input bit rdy, input int lat, input bit spur);
        bit          rd_eff;
        bit          v;
        bit          exp_req;
        logic [31:0] d;
        @(posedge clk);
        #1;
        // Redirects are not issued in a cycle that sends a request.
        rd_eff = rd && !m_req_pend;
        v = 1'b0;
        d = $urandom;
        if (r) resp_cnt = 0;
        else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                v = 1'b1;
                d = mem_word(resp_addr);
            end
        end else if (spur && m_valid) v = 1'b1;
        rst = r; redirect = rd_eff; redirect_target = tg;
        inst_ready = rdy; imem_valid = v; imem_rdata = d;

        @(negedge clk);
        cyc++;
        exp_req = m_known && m_req_pend && !r;
        chk("imem_req", 64'(imem_req), 64'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, m_fpc);
        if (m_known) begin
            chk("inst_valid", 64'(inst_valid), 64'(m_valid));
            chk("inst", 64'(inst), 64'(m_inst));
            chk("inst_pc", inst_pc, m_pc);
        end
        if (imem_req) req_log.push_back(imem_addr);
        if (inst_valid) begin
            vpc_log.push_back(inst_pc);
            vinst_log.push_back(inst);
            vcyc_log.push_back(cyc);
        end
        if (imem_req && !r) begin
            resp_cnt  = lat;
            resp_addr = imem_addr;
        end

        if (r) begin
            m_known = 1'b1; m_req_pend = 1'b1; m_busy = 1'b0; m_discard = 1'b0;
            m_valid = 1'b0; m_inst = 32'h0; m_pc = 64'h0; m_fpc = RPC;
        end else if (!m_known) begin
            m_req_pend = 1'b0;
        end else if (rd_eff) begin
            m_fpc = {tg[63:2], 2'b00};
            m_valid = 1'b0;
            if (m_busy) begin
                if (v) begin m_busy = 1'b0; m_req_pend = 1'b1; end
                else m_discard = 1'b1;
            end else m_req_pend = 1'b1;
        end else if (m_req_pend) begin
            m_req_pend = 1'b0; m_busy = 1'b1; m_discard = 1'b0;
        end else if (m_busy) begin
            if (v) begin
                m_busy = 1'b0;
                if (m_discard) m_req_pend = 1'b1;
                else if (SQUASH && d == NOP) begin
                    m_fpc = m_fpc + 64'd4; m_req_pend = 1'b1;
                end else begin
                    m_valid = 1'b1; m_inst = d; m_pc = m_fpc;
                end
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0; m_fpc = m_fpc + 64'd4; m_req_pend = 1'b1;
        end
    endtask

    task automatic do_reset();
        tick(1, 0, 64'h0, 0, 1, 0);
        tick(1, 0, 64'h0, 0, 1, 0);
        clear_logs();
    endtask

    initial begin
        int n;
        bit r, rd, rdy, spur;
        logic [63:0] tg;

        // Straight-line fetch from RESET_PC with 1-cycle memory.
        do_reset();
        repeat (12) tick(0, 0, 64'h0, 1, 1, 0);
        chk("a_nreq", 64'(req_log.size() >= 3), 64'd1);
        if (req_log.size() >= 3) begin
            chk("a_addr0", req_log[0], 64'h1000);
            chk("a_addr1", req_log[1], 64'h1004);
            chk("a_addr2", req_log[2], 64'h1008);
        end
        chk("a_nvalid", 64'(vpc_log.size()), SQUASH ? 64'd3 : 64'd4);
        if (vpc_log.size() >= 2) begin
            chk("a_spacing", 64'(vcyc_log[1] - vcyc_log[0]), 64'd3);
            if (SQUASH) begin
                chk("a_pc0", vpc_log[0], 64'h1004);
                chk("a_inst0", 64'(vinst_log[0]), 64'h8B020020);
                chk("a_pc1", vpc_log[1], 64'h1008);
            end else begin
                chk("a_pc0", vpc_log[0], 64'h1000);
                chk("a_inst0", 64'(vinst_log[0]), 64'(NOP));
                chk("a_pc1", vpc_log[1], 64'h1004);
                chk("a_inst1", 64'(vinst_log[1]), 64'h8B020020);
            end
        end

        // Redirect coincident with the response, then decode stalls.
        do_reset();
        tick(0, 0, 64'h0, 0, 1, 0);
        tick(0, 1, 64'h2043, 0, 1, 0);
        repeat (9) tick(0, 0, 64'h0, 0, 1, 0);
        tick(0, 0, 64'h0, 1, 1, 0);
        repeat (2) tick(0, 0, 64'h0, 0, 1, 0);
        chk("b_nreq", 64'(req_log.size()), 64'd3);
        if (req_log.size() >= 3) begin
            chk("b_addr1", req_log[1], 64'h2040);
            chk("b_addr2", req_log[2], 64'h2044);
        end
        n = 0;
        foreach (vpc_log[i]) if (vpc_log[i] == 64'h2040) n++;
        chk("b_nvalid", 64'(vpc_log.size()), 64'd8);
        chk("b_hold_pc", 64'(n), 64'd8);

        // Redirect while waiting; response lands two cycles later.
        do_reset();
        tick(0, 0, 64'h0, 1, 3, 0);
        tick(0, 1, 64'h2003, 1, 1, 0);
        repeat (5) tick(0, 0, 64'h0, 1, 1, 0);
        chk("c_nreq", 64'(req_log.size()), 64'd2);
        if (req_log.size() >= 2) chk("c_addr1", req_log[1], 64'h2000);
        chk("c_nvalid", 64'(vpc_log.size()), 64'd1);
        if (vpc_log.size() >= 1) chk("c_pc0", vpc_log[0], 64'h2000);

        // PC wrap at the top of the address space.
        do_reset();
        tick(0, 0, 64'h0, 1, 1, 0);
        tick(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 0);
        repeat (4) tick(0, 0, 64'h0, 1, 1, 0);
        chk("d_nreq", 64'(req_log.size()), 64'd3);
        if (req_log.size() >= 3) begin
            chk("d_addr1", req_log[1], 64'hFFFF_FFFF_FFFF_FFFC);
            chk("d_addr2", req_log[2], 64'h0);
        end

        // Random traffic against the model.
        do_reset();
        repeat (4000) begin
            r    = ($urandom % 300) == 0;
            rd   = ($urandom % 10) == 0;
            rdy  = ($urandom % 3) != 0;
            spur = ($urandom % 4) == 0;
            if (($urandom % 4) == 0) tg = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom % 16);
            else tg = {$urandom, $urandom};
            tick(r, rd, tg, rdy, int'($urandom_range(1, 3)), spur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
